// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and stage record for the NTT modular-arithmetic pipelines
package ntt_pkg;
  localparam int LOGQ_DEF = 32;
  localparam int DELAY_SUB_ONE = 1;
  localparam int DELAY_SUB_TWO = 2;
  typedef struct packed {
    logic                valid;
    logic [LOGQ_DEF-1:0] data;
    logic [LOGQ_DEF-1:0] q;
  } stage_t;
  function automatic bit delay_sub_ok(int d);
    return d == DELAY_SUB_ONE || d == DELAY_SUB_TWO;
  endfunction
endpackage

// File: rtl/modsub_stage_reg.sv
// modsub_stage_reg: valid/data register slice with bubble-collapsing advance
//   valid_i/data_i : upstream slot, taken when adv_o is high
//   adv_next_i     : downstream stage (or out_ready) can take this slot
//   valid_o/data_o : held slot contents
//   adv_o          : this slot may be overwritten this cycle
module modsub_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         adv_next_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         adv_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign adv_o = !valid_q || adv_next_i;
  always_comb begin
    valid_d = adv_o ? valid_i : valid_q;
    data_d  = adv_o && valid_i ? data_i : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/modsub_pipe.sv
// modsub_pipe: pipelined c = (a - b) mod q, optionally halved mod q, valid/ready stream
//   in_valid/in_ready   : operand handshake for a, b, q (q ignored when IS_Q_FIXED)
//   out_valid/out_ready : result handshake for c
module modsub_pipe
  import ntt_pkg::*;
#(
  parameter int              LOGQ       = LOGQ_DEF,
  parameter bit              IS_Q_FIXED = 1'b0,
  parameter logic [LOGQ-1:0] Q          = '0,
  parameter int              DELAY_SUB  = DELAY_SUB_TWO,
  parameter bit              DIV2       = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] c
);
  if (!delay_sub_ok(DELAY_SUB)) begin : g_bad_delay
    $fatal(1, "modsub_pipe: DELAY_SUB must be 1 or 2");
  end
  logic [LOGQ-1:0] q_in, cq, r;
  logic [LOGQ:0]   d, cd;
  logic            cv, cor_adv;
  assign q_in = IS_Q_FIXED ? Q : q;
  assign d    = {1'b0, a} - {1'b0, b};
  if (DELAY_SUB == DELAY_SUB_TWO) begin : g_sub
    modsub_stage_reg #(.W(2*LOGQ+1)) u_sub (
      .clk, .rst,
      .valid_i(in_valid), .data_i({q_in, d}), .adv_next_i(cor_adv),
      .valid_o(cv), .data_o({cq, cd}), .adv_o(in_ready)
    );
  end else begin : g_nosub
    assign cv       = in_valid;
    assign cd       = d;
    assign cq       = q_in;
    assign in_ready = cor_adv;
  end
  // A borrow means a < b; adding q in LOGQ bits wraps the difference back into [0, q).
  assign r = cd[LOGQ] ? cd[LOGQ-1:0] + cq : cd[LOGQ-1:0];
  if (DIV2) begin : g_div2
    logic            rv, half_adv;
    logic [LOGQ-1:0] rd, rq;
    logic [LOGQ:0]   hs;
    modsub_stage_reg #(.W(2*LOGQ)) u_cor (
      .clk, .rst,
      .valid_i(cv), .data_i({cq, r}), .adv_next_i(half_adv),
      .valid_o(rv), .data_o({rq, rd}), .adv_o(cor_adv)
    );
    // Odd r is made even by adding the odd modulus; the carry is kept so the shift is exact.
    assign hs = rd[0] ? {1'b0, rd} + {1'b0, rq} : {1'b0, rd};
    // The final slot stores only the result: nothing downstream consumes its modulus.
    modsub_stage_reg #(.W(LOGQ)) u_half (
      .clk, .rst,
      .valid_i(rv), .data_i(LOGQ'(hs >> 1)), .adv_next_i(out_ready),
      .valid_o(out_valid), .data_o(c), .adv_o(half_adv)
    );
  end else begin : g_nodiv
    modsub_stage_reg #(.W(LOGQ)) u_cor (
      .clk, .rst,
      .valid_i(cv), .data_i(r), .adv_next_i(out_ready),
      .valid_o(out_valid), .data_o(c), .adv_o(cor_adv)
    );
  end
endmodule

// File: tb/tb_modsub_pipe.sv
// tb_modsub_pipe: scoreboard bench over four modsub_pipe configurations
module tb_modsub_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[4], irdy[4], ov[4], ordy[4];
  logic [31:0] ia[4], ib[4], iq[4], cw[4];
  logic [4:0]  c0, c1;
  logic [13:0] c2;
  logic [31:0] c3;
  int          checks = 0, fails = 0, cyc = 0;
  logic        hold[4];
  logic [31:0] held_c[4];
  typedef struct {int inst; logic [31:0] exp; int lat; int t;} exp_t;
  exp_t sb[$];
  typedef struct {int k; logic [31:0] a, b, q, e; int lat;} vec_t;
  vec_t vt[15] = '{
    '{0, 5, 3, 17, 2, 2}, '{0, 3, 5, 17, 15, 2}, '{0, 7, 7, 17, 0, 2},
    '{0, 0, 16, 17, 1, 2}, '{0, 2, 9, 13, 6, 2},
    '{1, 3, 5, 17, 16, 3}, '{1, 16, 0, 17, 8, 3}, '{1, 0, 1, 17, 8, 3}, '{1, 5, 4, 17, 9, 3},
    '{2, 1, 2, 0, 12288, 2}, '{2, 12288, 0, 0, 12288, 2}, '{2, 100, 300, 0, 12089, 2},
    '{3, 0, 32'hFFFFFFFA, 32'hFFFFFFFB, 1, 1},
    '{3, 1, 32'hFFFFFFFA, 32'hFFFFFFFB, 2, 1},
    '{3, 32'hFFFFFFFA, 0, 32'hFFFFFFFB, 32'hFFFFFFFA, 1}
  };
  int ba[10] = '{1, 16, 0, 9, 12, 3, 10, 15, 2, 8};
  int bb[10] = '{2, 15, 0, 14, 4, 16, 10, 1, 11, 13};
  int bc[10] = '{16, 1, 0, 12, 8, 4, 0, 14, 8, 12};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  modsub_pipe #(.LOGQ(5), .DELAY_SUB(2), .DIV2(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(ia[0][4:0]), .b(ib[0][4:0]), .q(iq[0][4:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .c(c0));
  modsub_pipe #(.LOGQ(5), .DELAY_SUB(2), .DIV2(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(ia[1][4:0]), .b(ib[1][4:0]), .q(iq[1][4:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .c(c1));
  modsub_pipe #(.LOGQ(14), .IS_Q_FIXED(1'b1), .Q(14'd12289), .DELAY_SUB(2), .DIV2(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(ia[2][13:0]), .b(ib[2][13:0]), .q(iq[2][13:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .c(c2));
  modsub_pipe #(.LOGQ(32), .DELAY_SUB(1), .DIV2(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .a(ia[3]), .b(ib[3]), .q(iq[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .c(c3));

  always_comb begin
    cw[0] = {27'b0, c0};
    cw[1] = {27'b0, c1};
    cw[2] = {18'b0, c2};
    cw[3] = c3;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (hold[k]) begin
        chk($sformatf("stall_valid[%0d]", k), {31'b0, ov[k]}, 1);
        chk($sformatf("stall_c[%0d]", k), cw[k], held_c[k]);
      end
      if (ov[k] && ordy[k]) begin
        if (sb.size() == 0 || sb[0].inst != k) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out[%0d]: got %0d, expected no result", k, cw[k]);
        end else begin
          e = sb.pop_front();
          chk($sformatf("c[%0d]", k), cw[k], e.exp);
          if (e.lat >= 0) chk($sformatf("latency[%0d]", k), 32'(cyc - e.t), 32'(e.lat));
        end
      end
      hold[k]   = ov[k] && !ordy[k];
      held_c[k] = cw[k];
    end
  end

  task automatic send(int k, logic [31:0] a, logic [31:0] b, logic [31:0] qq, logic [31:0] e, int lat);
    int  n = 0;
    bit  done = 1'b0;
    iv[k] = 1'b1;
    ia[k] = a;
    ib[k] = b;
    iq[k] = qq;
    while (!done) begin
      @(negedge clk);
      if (irdy[k]) begin
        sb.push_back('{k, e, lat, cyc});
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          fails++;
          $display("FAIL accept_timeout[%0d]: got in_ready=0 for %0d cycles, expected acceptance", k, n);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; iq[k] = '0;
      ordy[k] = 1'b1; hold[k] = 1'b0; held_c[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid[%0d]", k), {31'b0, ov[k]}, 0);
      chk($sformatf("rst_c[%0d]", k), cw[k], 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("rst_in_ready[%0d]", k), {31'b0, irdy[k]}, 1);
    foreach (vt[i]) begin
      send(vt[i].k, vt[i].a, vt[i].b, vt[i].q, vt[i].e, vt[i].lat);
      iv[vt[i].k] = 1'b0;
      drain();
    end
    fork
      begin
        for (int i = 0; i < 10; i++) send(0, ba[i], bb[i], 17, bc[i], -1);
        iv[0] = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 ordy[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("bp_in_ready", {31'b0, irdy[0]}, 0);
        chk("bp_out_valid", {31'b0, ov[0]}, 1);
        chk("bp_occupancy", sb.size(), 2);
        repeat (2) @(posedge clk);
        #1 ordy[0] = 1'b1;
      end
    join
    drain();
    send(0, 1, 2, 17, 16, -1);
    send(0, 6, 2, 17, 4, -1);
    rst = 1'b1;
    iv[0] = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ov[0]}, 0);
    chk("midrst_c", cw[0], 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {31'b0, irdy[0]}, 1);
    send(0, 4, 9, 17, 12, 2);
    iv[0] = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/modsub_pipe.md
Name: modsub_pipe

Overview:
- Pipelined modular subtractor computing c = (a - b) mod q, optionally followed by a modular halving (c = (a - b)/2 mod q).
- Companion to the modular adder: it supplies the difference leg of Gentleman-Sande and inverse-NTT butterflies.
- Adds a valid/ready stream interface with per-stage backpressure, so it can sit between BRAM readers and the butterfly writeback FIFO.

Parameters:
- LOGQ, 32: coefficient and modulus width in bits.
- IS_Q_FIXED, 0: when 1, the constant Q is used and the q port is ignored.
- Q, 0: fixed modulus, used only when IS_Q_FIXED=1.
- DELAY_SUB, 2: subtract/correct stages. 1 means subtract and correct in one registered stage. 2 means a registered subtract followed by a registered correct. Other values are illegal; elaboration must fail on them.
- DIV2, 0: when 1, appends one registered modular-halving stage.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts an input this cycle
- a  in  LOGQ  minuend; 0 <= a < q
- b  in  LOGQ  subtrahend; 0 <= b < q
- q  in  LOGQ  modulus, odd, captured per transaction; ignored if IS_Q_FIXED=1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- c  out  LOGQ  result

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits clear to 0 and all stage data registers clear to 0.
  - out_valid=0, c=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline depth and latency:
  - Number of stages L = DELAY_SUB + DIV2.
  - Latency is L cycles from input transfer to out_valid when not stalled.
  - Throughput is 1 result per cycle.
- Stage data and q handling:
  - Each stage holds a valid bit, its data, and its own copy of q_eff.
  - q_eff = Q if IS_Q_FIXED=1, otherwise the q sampled at input transfer.
  - Different transactions may therefore carry different moduli.
- Subtract: d = {1'b0,a} - {1'b0,b}, computed in LOGQ+1 bits, two's complement.
- Correct: r = d[LOGQ] ? d[LOGQ-1:0] + q_eff : d[LOGQ-1:0]. The sum is computed in LOGQ bits; the wrap is intended and gives a result in [0, q).
- Halve (DIV2=1):
  - h = r[0] ? ({1'b0,r} + q_eff) >> 1 : r >> 1.
  - The sum is computed in LOGQ+1 bits so no carry is lost.
- Stall control (bubble-collapsing):
  - Stage i advances when !valid_i || advance_{i+1}.
  - The last stage advances when !out_valid || out_ready.
  - in_ready = advance of stage 0, combinational from downstream ready/valid; there is no combinational path from in_valid to in_ready.
  - A stage holding valid data keeps data and q stable while stalled.
- Invariants:
  - Results leave in input order.
  - No drop and no duplication under any out_ready pattern.
  - c and out_valid hold while out_valid && !out_ready.
- Boundary cases:
  - a==b gives 0.
  - b>a wraps via +q.
  - a=0, b=q-1 gives 1.
  - Full pipeline with out_ready=0: in_ready=0 and nothing is accepted.
  - Input and output transfer in the same cycle when full: both occur, occupancy unchanged.
  - rst mid-stream: all in-flight data is discarded immediately; no partial result appears after reset.
- Out-of-range inputs (a or b >= q, or even q with DIV2=1): output undefined but the handshake remains correct.

Decomposition:
- Shared package (ntt_pkg): LOGQ default, the DELAY_* constants, and a stage-record typedef {valid, data[LOGQ-1:0], q[LOGQ-1:0]}.
- One sub-module, modsub_stage_reg: a generic valid/data/q register slice with advance logic, instantiated L times. The arithmetic lives between the slices in modsub_pipe.

Test Plan:
- Basic, LOGQ=5, q=17, DELAY_SUB=2, DIV2=0:
  - a=5, b=3 -> c=2, out_valid exactly 2 cycles after the transfer.
  - a=3, b=5 -> c=15.
  - a=7, b=7 -> c=0.
- Halving, DIV2=1, q=17:
  - a=3, b=5 -> c=16 (odd 15, (15+17)/2).
  - a=16, b=0 -> c=8.
  - Latency 3.
- Fixed Q, IS_Q_FIXED=1, Q=12289, q port driven 0:
  - a=1, b=2 -> c=12288.
  - a=12288, b=0 -> c=12288.
- Wide modulus, LOGQ=32, q=2^32-5: a=0, b=q-1 -> c=1, checking no overflow in the correct stage.
- Backpressure:
  - Stream 10 random pairs with out_ready=0 for cycles 3..8.
  - in_ready must fall once L results are held.
  - All 10 results must match the model, in order, with c stable during the stall.
- Reset mid-operation:
  - Assert rst while 2 transactions are in flight.
  - out_valid=0 and c=0 immediately; in_ready=1 after release.
  - The next transaction a=4, b=9, q=17 -> c=12 with normal latency.
